bp_resolve_queue: RTL
=====================

Name: bp_resolve_queue

Overview:
- In-order queue holding branch predictions in flight between fetch and execute.
- Fetch pushes each predicted branch. Execute resolves branches oldest-first.
- On each resolve the block emits a registered training update toward the bimodal predictor (its branch_en / branch_result / PC inputs).
- On a misprediction it emits a redirect and flushes all younger wrong-path entries.

Parameters:
DEPTH, 8, number of in-flight branch entries (power of 2, >=2)
PC_W, 32, program counter width
IDX_W, 14, predictor index width (PC bits [IDX_W+1:2])

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
push_valid  in  1  fetch presents a predicted branch
push_ready  out  1  queue can accept (not full)
push_pc  in  PC_W  branch instruction PC
push_pred_taken  in  1  predictor decision
push_pred_target  in  PC_W  predicted target (used when push_pred_taken=1)
push_tag  out  $clog2(DEPTH)  slot tag assigned to the accepted push
res_valid  in  1  execute resolves the oldest branch
res_tag  in  $clog2(DEPTH)  tag of the resolving branch
res_taken  in  1  actual direction
res_target  in  PC_W  actual taken target
upd_en  out  1  predictor training strobe
upd_taken  out  1  actual direction for training
upd_idx  out  IDX_W  predictor index = pc[IDX_W+1:2]
redirect_valid  out  1  mispredict: fetch must restart
redirect_pc  out  PC_W  correct next PC
tag_err  out  1  sticky: resolve on empty queue or tag != head

Behaviour:
- Reset (rst=0, async): head=tail=count=0; all outputs 0; push_ready=1 once reset is released. Entry storage is not reset.
- Storage and pointers:
  - Circular buffer of DEPTH entries {pc, pred_taken, pred_target}.
  - head/tail are $clog2(DEPTH) bits and wrap naturally.
  - count is $clog2(DEPTH)+1 bits.
- Push:
  - Accepted when push_valid && push_ready.
  - Writes slot tail and increments tail.
  - push_tag = tail (combinational, valid the same cycle).
- push_ready = (count != DEPTH), derived from registered count only. A same-cycle resolve does not free space for a push when full.
- Resolve, with res_valid=1:
  - If count==0 or res_tag!=head: set tag_err (sticky until reset). Queue unchanged. No upd_en, no redirect.
  - Otherwise: pop head. Compute mispredict = (res_taken != pred_taken) || (res_taken && pred_taken && res_target != pred_target).
- Outputs registered; latency 1 cycle. Resolve in cycle N gives outputs in cycle N+1, each a single-cycle pulse:
  - upd_en=1, upd_taken=res_taken, upd_idx=head.pc[IDX_W+1:2].
  - On mispredict: redirect_valid=1, redirect_pc = res_taken ? res_target : head.pc+4 (mod 2^PC_W).
- Flush on mispredict, at the same edge as the pop: head=tail=count=0. All younger entries are discarded.
- Simultaneous push + mispredicting resolve: the push is dropped (wrong-path) and not counted. push_tag that cycle is don't-care.
- Simultaneous push + correct resolve: both take effect; count unchanged.
- A push with push_valid while full is ignored. No state change, no error.
- Counters/flags in the same cycle:
  - upd_en and redirect_valid are never asserted without a valid, matching resolve.
  - tag_err never clears except by reset.
- Reset asserted mid-operation: queue empties immediately and output pulses are cancelled. First push after release gets tag 0.

Decomposition:
- Shared package bp_pkg:
  - typedef bp_entry_t {pc, pred_taken, pred_target}.
  - Constants BP_IDX_W=14, INSTR_BYTES=4.
  - Function pc_to_idx().
- One natural sub-module: bp_circ_fifo (storage, pointers, count, full/empty, flush input). The top adds mispredict compare, output registers and tag checking.

Test Plan:
- Reset then idle: after rst release, push_ready=1, upd_en=0, redirect_valid=0, tag_err=0, and nothing changes for 10 cycles.
- Correct prediction: push pc=0x100 taken target=0x200 (tag 0); resolve tag 0 taken target 0x200 -> next cycle upd_en=1, upd_taken=1, upd_idx=0x40, redirect_valid=0; count back to 0.
- Direction mispredict with flush: push pc=0x100 not-taken, then 0x104 and 0x108; resolve tag 0 taken target 0x300 -> redirect_valid=1, redirect_pc=0x300, upd_taken=1; queue empty; next push gets tag 0.
- Fall-through mispredict: push pc=0x1FC predicted taken target 0x40; resolve not-taken -> redirect_pc=0x200, upd_taken=0.
- Full / wrap: push 8 entries (push_ready drops after the 8th); 9th push ignored; resolve tags 0..7 in order with correct outcomes -> 8 upd_en pulses and no tag_err; push 8 more -> tags 0..7 again.
- Errors and simultaneity:
  - Resolve on empty -> tag_err=1, held.
  - With 2 entries, resolve tag 1 -> tag_err=1, no upd_en.
  - Push concurrent with a mispredicting resolve -> push dropped, count=0.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch-prediction resolve queue.
package bp_pkg;

    localparam int unsigned BP_PC_W     = 32;
    localparam int unsigned BP_IDX_W    = 14;
    localparam int unsigned INSTR_BYTES = 4;

    typedef struct packed {
        logic [BP_PC_W-1:0] pc;
        logic               pred_taken;
        logic [BP_PC_W-1:0] pred_target;
    } bp_entry_t;

    // Predictor index drops the byte offset within an instruction word.
    function automatic logic [BP_IDX_W-1:0] pc_to_idx(input logic [BP_PC_W-1:0] pc);
        return BP_IDX_W'(pc >> $clog2(INSTR_BYTES));
    endfunction

endpackage

// File: rtl/bp_circ_fifo.sv
// Circular buffer with naturally wrapping pointers, occupancy count and a flush-to-empty input.
module bp_circ_fifo
    import bp_pkg::*;
#(
    parameter int unsigned Depth = 8,
    parameter type entry_t = bp_entry_t,
    localparam int unsigned PtrW = $clog2(Depth)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push_i,
    input  entry_t          wdata_i,
    input  logic            pop_i,
    input  logic            flush_i,
    output entry_t          rdata_o,
    output logic [PtrW-1:0] head_o,
    output logic [PtrW-1:0] tail_o,
    output logic            full_o,
    output logic            empty_o
);

    entry_t          mem_q [Depth];
    logic [PtrW-1:0] head_q, head_d;
    logic [PtrW-1:0] tail_q, tail_d;
    logic [PtrW:0]   count_q, count_d;
    logic            do_push, do_pop;

    assign full_o  = (count_q == (PtrW+1)'(Depth));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[head_q];
    assign head_o  = head_q;
    assign tail_o  = tail_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) tail_d = tail_q + PtrW'(1);
            if (do_pop)  head_d = head_q + PtrW'(1);
            count_d = count_q + (PtrW+1)'(do_push) - (PtrW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage is deliberately left unreset.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[tail_q] <= wdata_i;
    end

endmodule

// File: rtl/bp_resolve_queue.sv
// In-order queue of in-flight branch predictions; resolves oldest-first, trains the
// predictor and redirects fetch with a full flush on a mispredict.
module bp_resolve_queue
    import bp_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PC_W  = BP_PC_W,
    parameter int unsigned IDX_W = BP_IDX_W,
    localparam int unsigned TagW = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push_valid,
    output logic            push_ready,
    input  logic [PC_W-1:0] push_pc,
    input  logic            push_pred_taken,
    input  logic [PC_W-1:0] push_pred_target,
    output logic [TagW-1:0] push_tag,
    input  logic            res_valid,
    input  logic [TagW-1:0] res_tag,
    input  logic            res_taken,
    input  logic [PC_W-1:0] res_target,
    output logic            upd_en,
    output logic            upd_taken,
    output logic [IDX_W-1:0] upd_idx,
    output logic            redirect_valid,
    output logic [PC_W-1:0] redirect_pc,
    output logic            tag_err
);

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            pred_taken;
        logic [PC_W-1:0] pred_target;
    } entry_t;

    entry_t          push_e, head_e;
    logic [TagW-1:0] head_tag, tail_tag;
    logic            fifo_full, fifo_empty;
    logic            res_ok, mispredict, flush;

    logic             upd_en_q, upd_taken_q, redirect_valid_q, tag_err_q;
    logic [IDX_W-1:0] upd_idx_q;
    logic [PC_W-1:0]  redirect_pc_q;

    assign push_e.pc          = push_pc;
    assign push_e.pred_taken  = push_pred_taken;
    assign push_e.pred_target = push_pred_target;

    bp_circ_fifo #(
        .Depth   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .push_i  (push_valid),
        .wdata_i (push_e),
        .pop_i   (res_ok),
        .flush_i (flush),
        .rdata_o (head_e),
        .head_o  (head_tag),
        .tail_o  (tail_tag),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign push_ready = !fifo_full;
    assign push_tag   = tail_tag;

    assign res_ok     = res_valid && !fifo_empty && (res_tag == head_tag);
    assign mispredict = (res_taken != head_e.pred_taken) ||
                        (res_taken && head_e.pred_taken && (res_target != head_e.pred_target));
    // A flush also drops any same-cycle push, which is on the wrong path.
    assign flush      = res_ok && mispredict;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            upd_en_q         <= 1'b0;
            upd_taken_q      <= 1'b0;
            upd_idx_q        <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            tag_err_q        <= 1'b0;
        end else begin
            upd_en_q         <= res_ok;
            upd_taken_q      <= res_ok && res_taken;
            upd_idx_q        <= res_ok ? IDX_W'(head_e.pc >> $clog2(INSTR_BYTES)) : '0;
            redirect_valid_q <= flush;
            if (flush) begin
                redirect_pc_q <= res_taken ? res_target : head_e.pc + PC_W'(INSTR_BYTES);
            end else begin
                redirect_pc_q <= '0;
            end
            tag_err_q        <= tag_err_q || (res_valid && !res_ok);
        end
    end

    assign upd_en         = upd_en_q;
    assign upd_taken      = upd_taken_q;
    assign upd_idx        = upd_idx_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign tag_err        = tag_err_q;

endmodule
